// File: rtl/uart_echo_tester_if.sv
// UART-side connection of the echo tester: TX send strobe plus the RX byte-valid level.
// master = the tester, slave = the UART core (or a bench model standing in for it).
interface uart_echo_tester_if;
    // Handshake: a send happens only in a cycle where tx_trigger is high; the master raises
    // tx_trigger for exactly one cycle and only after sampling tx_ready high, and holds tx_data
    // from that trigger until the next one. rx_byte_ready is a level: rx_data is valid while it
    // is high, and only its rising edge marks a new received byte.
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_trigger;
    logic       rx_byte_ready;
    logic [7:0] rx_data;

    modport master (
        input  tx_ready,
        input  rx_byte_ready,
        input  rx_data,
        output tx_data,
        output tx_trigger
    );

    modport slave (
        output tx_ready,
        output rx_byte_ready,
        output rx_data,
        input  tx_data,
        input  tx_trigger
    );
endinterface

// File: rtl/uart_echo_tester.sv
// Initiator-side UART loopback self-test: sends a byte pattern, checks each echo, counts results.
// Optional: define UART_ECHO_TESTER_LFSR_EN for an 8-bit Galois LFSR pattern (default: incrementing byte).
module uart_echo_tester #(
    parameter int         NUM_BYTES      = 256,
    parameter int         GAP_CYCLES     = 1000,
    parameter int         TIMEOUT_CYCLES = 27000,
    parameter logic [7:0] SEED           = 8'h01
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    uart_echo_tester_if.master    uart,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           pass_count_o,
    output logic [15:0]           err_count_o,
    output logic [7:0]            timeout_count_o,
    output logic                  last_err_o,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TX   = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_GAP       = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [31:0]      NB_L     = 32'(NUM_BYTES);

`ifdef UART_ECHO_TESTER_LFSR_EN
    localparam logic [7:0] LFSR_MASK = 8'hB8;
    // An all-zero LFSR state would lock up, so a zero seed is replaced.
    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
`else
    localparam logic [7:0] SEED_EFF  = SEED;
`endif

    function automatic logic [7:0] next_pattern(input logic [7:0] p);
`ifdef UART_ECHO_TESTER_LFSR_EN
        logic [7:0] fb;
        // Feedback is folded in before the shift, so 8'h01 steps to 8'h5C, 8'h2E, 8'h17.
        fb = p[0] ? LFSR_MASK : 8'h00;
        return (p ^ fb) >> 1;
`else
        return p + 8'd1;
`endif
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        pattern_q, pattern_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              trig_q, trig_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [31:0]       idx_q, idx_d;
    logic              stop_q, stop_d;
    logic [15:0]       pass_q, pass_d;
    logic [15:0]       err_q, err_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic              last_err_q, last_err_d;
    logic              rx_prev_q;
    logic              echo;
    logic              last_byte;

    // Only a fresh rising edge of the RX level counts; a level already high is never an echo.
    assign echo      = uart.rx_byte_ready & ~rx_prev_q;
    assign last_byte = (NUM_BYTES != 0) && ((idx_q + 32'd1) == NB_L);

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        tx_data_d  = tx_data_q;
        trig_d     = 1'b0;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        pass_d     = pass_q;
        err_d      = err_q;
        tcnt_d     = tcnt_q;
        last_err_d = last_err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // start wins over a simultaneous stop and clears any stale stop request
                if (start_i) begin
                    state_d    = S_WAIT_TX;
                    pattern_d  = SEED_EFF;
                    idx_d      = '0;
                    stop_d     = 1'b0;
                    pass_d     = '0;
                    err_d      = '0;
                    tcnt_d     = '0;
                    last_err_d = 1'b0;
                end
            end

            S_WAIT_TX: begin
                if (stop_i) begin
                    state_d = S_DONE;
                end else if (uart.tx_ready) begin
                    trig_d    = 1'b1;
                    tx_data_d = pattern_q;
                    tmo_d     = TMO_LOAD;
                    state_d   = S_WAIT_ECHO;
                end
            end

            S_WAIT_ECHO: begin
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                // An echo landing on the expiry cycle is still scored as an echo.
                if (echo) begin
                    if (uart.rx_data == tx_data_q) begin
                        pass_d     = sat_inc16(pass_q);
                        last_err_d = 1'b0;
                    end else begin
                        err_d      = sat_inc16(err_q);
                        last_err_d = 1'b1;
                    end
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else if (tmo_q == '0) begin
                    tcnt_d     = sat_inc8(tcnt_q);
                    last_err_d = 1'b1;
                    gap_d      = GAP_LOAD;
                    state_d    = S_GAP;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end

            S_GAP: begin
                if (stop_i) begin
                    stop_d = 1'b1;
                end
                if (gap_q == '0) begin
                    pattern_d = next_pattern(pattern_q);
                    idx_d     = idx_q + 32'd1;
                    if (last_byte || stop_q || stop_i) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_TX;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pattern_q  <= SEED_EFF;
            tx_data_q  <= SEED_EFF;
            trig_q     <= 1'b0;
            tmo_q      <= '0;
            gap_q      <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            pass_q     <= '0;
            err_q      <= '0;
            tcnt_q     <= '0;
            last_err_q <= 1'b0;
            rx_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            tx_data_q  <= tx_data_d;
            trig_q     <= trig_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            tcnt_q     <= tcnt_d;
            last_err_q <= last_err_d;
            rx_prev_q  <= uart.rx_byte_ready;
        end
    end

    assign uart.tx_data    = tx_data_q;
    assign uart.tx_trigger = trig_q;

    assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o          = (state_q == S_DONE);
    assign pass_count_o    = pass_q;
    assign err_count_o     = err_q;
    assign timeout_count_o = tcnt_q;
    assign last_err_o      = last_err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester: four parameterisations share one clock, each with its own loopback model.
// Instance 0: 4 bytes from 8'h10; 1: 2 bytes from 8'hFF, 100-cycle timeout; 2: continuous; 3: 300 bytes, 2-cycle timeout.
module tb_uart_echo_tester;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TX   = 3'd1;
    localparam logic [2:0] ST_ECHO = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic       clk = 1'b0;
    int         cyc = 0;
    logic [3:0] rst;
    logic [3:0] start;
    logic [3:0] stop;
    logic [3:0] tx_ready;

    logic       rx_rdy   [4];
    logic [7:0] rx_d     [4];
    logic       tx_trig  [4];
    logic [7:0] tx_d     [4];
    logic       busy     [4];
    logic       done     [4];
    logic [15:0] pass_c  [4];
    logic [15:0] err_c   [4];
    logic [7:0] to_c     [4];
    logic       last_err [4];
    logic [2:0] st       [4];
    int         ntrig    [4];

    // Loopback model controls: 0 = silent, 1 = echo after dly cycles, 2 = RX level held high.
    int         mode     [4];
    int         dly      [4];
    logic       corr_en  [4];
    logic [7:0] corr_val [4];

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       sb_en  = 1'b0;
    int         sb_sel = 0;
    logic       lat_en = 1'b0;
    int         lat_exp = 0;
    int         t_trig = 0;
    logic [2:0] prev_st = ST_IDLE;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : inst
        localparam int         NB = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 0 : 300;
        localparam int         GP = (g == 0) ? 5 : (g == 3) ? 1 : 3;
        localparam int         TO = (g == 3) ? 2 : 100;
        localparam logic [7:0] SD = (g == 0) ? 8'h10 : (g == 1) ? 8'hFF : 8'h00;

        uart_echo_tester_if uif ();

        uart_echo_tester #(
            .NUM_BYTES      (NB),
            .GAP_CYCLES     (GP),
            .TIMEOUT_CYCLES (TO),
            .SEED           (SD)
        ) dut (
            .clk_i           (clk),
            .rst_i           (rst[g]),
            .start_i         (start[g]),
            .stop_i          (stop[g]),
            .uart            (uif),
            .busy_o          (busy[g]),
            .done_o          (done[g]),
            .pass_count_o    (pass_c[g]),
            .err_count_o     (err_c[g]),
            .timeout_count_o (to_c[g]),
            .last_err_o      (last_err[g]),
            .dbg_state_o     (st[g])
        );

        assign uif.tx_ready      = tx_ready[g];
        assign uif.rx_byte_ready = rx_rdy[g];
        assign uif.rx_data       = rx_d[g];
        assign tx_trig[g]        = uif.tx_trigger;
        assign tx_d[g]           = uif.tx_data;

        always @(negedge clk) begin
            if (tx_trig[g]) ntrig[g] <= ntrig[g] + 1;
        end

        initial begin : echo_model
            logic [7:0] sent;
            rx_rdy[g] = 1'b0;
            rx_d[g]   = 8'h00;
            forever begin
                @(posedge clk);
                #1;
                if (mode[g] == 2) begin
                    rx_rdy[g] = 1'b1;
                end else if (mode[g] == 0) begin
                    rx_rdy[g] = 1'b0;
                end else if (tx_trig[g]) begin
                    sent = tx_d[g];
                    repeat (dly[g]) @(posedge clk);
                    #1;
                    rx_d[g]   = (corr_en[g] && sent == corr_val[g]) ? (sent ^ 8'h01) : sent;
                    rx_rdy[g] = 1'b1;
                    repeat (3) @(posedge clk);
                    #1;
                    rx_rdy[g] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard for the selected instance: bytes sent in order and trigger-to-GAP latency.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (sb_en && tx_trig[sb_sel]) begin
            t_trig = cyc;
            if (exp_q.size() == 0) begin
                check("sb_extra_trigger", 32'd1, 32'd0);
            end else begin
                exp_b = exp_q.pop_front();
                check("sb_tx_data", 32'(tx_d[sb_sel]), 32'(exp_b));
            end
        end
        if (lat_en && st[sb_sel] == ST_GAP && prev_st != ST_GAP)
            check("gap_latency", 32'(cyc - t_trig), 32'(lat_exp));
        prev_st = st[sb_sel];
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int g, input logic do_start, input logic do_stop);
        start[g] = do_start;
        stop[g]  = do_stop;
        tick(1);
        start[g] = 1'b0;
        stop[g]  = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, input string tag);
        int n = 0;
        while (done[g] !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(done[g]), 32'd1);
    endtask

    task automatic wait_state(input int g, input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (st[g] !== s && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(st[g]), 32'(s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int n;
        rst      = 4'hF;
        start    = 4'h0;
        stop     = 4'h0;
        tx_ready = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            mode[i]     = 0;
            dly[i]      = 50;
            corr_en[i]  = 1'b0;
            corr_val[i] = 8'h00;
        end
        tick(3);
        rst = 4'h0;

        check("rst_state", 32'(st[0]), 32'(ST_IDLE));
        check("rst_pass", 32'(pass_c[0]), 32'd0);
        check("rst_err", 32'(err_c[0]), 32'd0);
        check("rst_timeout", 32'(to_c[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_last_err", 32'(last_err[0]), 32'd0);
        check("rst_trigger", 32'(tx_trig[0]), 32'd0);
        check("rst_tx_data", 32'(tx_d[0]), 32'h10);

        // Ideal loopback, echo 50 cycles after each trigger.
        mode[0] = 1;
        dly[0]  = 50;
        sb_sel  = 0;
        sb_en   = 1'b1;
        lat_en  = 1'b1;
        lat_exp = 51;
        exp_q   = '{8'h10, 8'h11, 8'h12, 8'h13};
        pulse(0, 1'b1, 1'b0);
        check("run_busy", 32'(busy[0]), 32'd1);
        wait_done(0, 2000, "ideal_done");
        check("ideal_pass", 32'(pass_c[0]), 32'd4);
        check("ideal_err", 32'(err_c[0]), 32'd0);
        check("ideal_timeout", 32'(to_c[0]), 32'd0);
        check("ideal_busy", 32'(busy[0]), 32'd0);
        check("ideal_sb_empty", 32'(exp_q.size()), 32'd0);

        // Third byte corrupted on the way back.
        corr_en[0]  = 1'b1;
        corr_val[0] = 8'h12;
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        pulse(0, 1'b1, 1'b0);
        wait_done(0, 2000, "corrupt_done");
        check("corrupt_pass", 32'(pass_c[0]), 32'd3);
        check("corrupt_err", 32'(err_c[0]), 32'd1);
        check("corrupt_timeout", 32'(to_c[0]), 32'd0);
        check("corrupt_last_err", 32'(last_err[0]), 32'd0);
        check("corrupt_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset while the second byte waits for its echo.
        corr_en[0] = 1'b0;
        sb_en  = 1'b0;
        lat_en = 1'b0;
        pulse(0, 1'b1, 1'b0);
        n = 0;
        while (pass_c[0] != 16'd1 && n < 500) begin
            tick(1);
            n++;
        end
        check("rst_mid_first_pass", 32'(pass_c[0]), 32'd1);
        wait_state(0, ST_ECHO, 500, "rst_mid_wait_echo");
        check("rst_mid_tx_data_pre", 32'(tx_d[0]), 32'h11);
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        check("rst_mid_state", 32'(st[0]), 32'(ST_IDLE));
        check("rst_mid_pass", 32'(pass_c[0]), 32'd0);
        check("rst_mid_trigger", 32'(tx_trig[0]), 32'd0);
        check("rst_mid_busy", 32'(busy[0]), 32'd0);
        check("rst_mid_tx_data", 32'(tx_d[0]), 32'h10);
        tick(80);
        check("idle_echo_ignored", 32'(pass_c[0]), 32'd0);
        check("idle_stays_idle", 32'(st[0]), 32'(ST_IDLE));
        mode[0] = 0;

        // No echo at all: both bytes time out, GAP entered 100 cycles after each trigger.
        mode[1] = 0;
        sb_sel  = 1;
        sb_en   = 1'b1;
        lat_en  = 1'b1;
        lat_exp = 100;
        exp_q   = '{8'hFF, 8'h00};
        pulse(1, 1'b1, 1'b0);
        wait_done(1, 1000, "noecho_done");
        check("noecho_timeout", 32'(to_c[1]), 32'd2);
        check("noecho_pass", 32'(pass_c[1]), 32'd0);
        check("noecho_err", 32'(err_c[1]), 32'd0);
        check("noecho_last_err", 32'(last_err[1]), 32'd1);
        check("noecho_sb_empty", 32'(exp_q.size()), 32'd0);

        // RX level already high at every trigger and never toggling.
        mode[1] = 2;
        tick(3);
        exp_q = '{8'hFF, 8'h00};
        pulse(1, 1'b1, 1'b0);
        wait_done(1, 1000, "held_done");
        check("held_pass", 32'(pass_c[1]), 32'd0);
        check("held_err", 32'(err_c[1]), 32'd0);
        check("held_timeout", 32'(to_c[1]), 32'd2);
        mode[1] = 0;
        tick(3);

        // Echo edge lands on the expiry cycle: echo wins.
        mode[1] = 1;
        dly[1]  = 99;
        exp_q   = '{8'hFF, 8'h00};
        pulse(1, 1'b1, 1'b0);
        wait_done(1, 1000, "expiry_done");
        check("expiry_pass", 32'(pass_c[1]), 32'd2);
        check("expiry_timeout", 32'(to_c[1]), 32'd0);
        check("expiry_last_err", 32'(last_err[1]), 32'd0);

        // Echo one cycle after expiry: timed out, late echo in GAP ignored.
        dly[1] = 100;
        exp_q  = '{8'hFF, 8'h00};
        pulse(1, 1'b1, 1'b0);
        wait_done(1, 1000, "late_done");
        check("late_pass", 32'(pass_c[1]), 32'd0);
        check("late_err", 32'(err_c[1]), 32'd0);
        check("late_timeout", 32'(to_c[1]), 32'd2);
        check("late_last_err", 32'(last_err[1]), 32'd1);
        sb_en   = 1'b0;
        lat_en  = 1'b0;
        mode[1] = 0;

        // Stop while stalled in WAIT_TX: straight to DONE, nothing sent.
        n0 = ntrig[2];
        pulse(2, 1'b1, 1'b0);
        tick(5);
        check("stall_state", 32'(st[2]), 32'(ST_TX));
        check("stall_no_trigger", 32'(ntrig[2] - n0), 32'd0);
        pulse(2, 1'b0, 1'b1);
        check("stall_stop_state", 32'(st[2]), 32'(ST_DONE));
        check("stall_stop_done", 32'(done[2]), 32'd1);
        check("stall_stop_no_trigger", 32'(ntrig[2] - n0), 32'd0);

        // Continuous run: start+stop together starts; stop during byte 5 echo wait.
        tx_ready[2] = 1'b1;
        mode[2] = 1;
        dly[2]  = 10;
        n0 = ntrig[2];
        pulse(2, 1'b1, 1'b1);
        check("startstop_state", 32'(st[2]), 32'(ST_TX));
        check("startstop_busy", 32'(busy[2]), 32'd1);
        n = 0;
        while ((ntrig[2] - n0) < 5 && n < 2000) begin
            tick(1);
            n++;
        end
        check("cont_fifth_trigger", 32'(ntrig[2] - n0), 32'd5);
        tick(2);
        check("cont_in_wait_echo", 32'(st[2]), 32'(ST_ECHO));
        pulse(2, 1'b0, 1'b1);
        wait_done(2, 1000, "cont_done");
        check("cont_triggers", 32'(ntrig[2] - n0), 32'd5);
        check("cont_pass", 32'(pass_c[2]), 32'd5);
        check("cont_err", 32'(err_c[2]), 32'd0);
        mode[2] = 0;

        // 300 timeouts: the 8-bit timeout count saturates at 8'hFF.
        n0 = ntrig[3];
        pulse(3, 1'b1, 1'b0);
        wait_done(3, 3000, "sat_done");
        check("sat_timeout", 32'(to_c[3]), 32'hFF);
        check("sat_triggers", 32'(ntrig[3] - n0), 32'd300);
        check("sat_pass", 32'(pass_c[3]), 32'd0);
        check("sat_last_err", 32'(last_err[3]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
